// File: rtl/imem_arb_if.sv
// imem_arb_if: bundle of the instruction-memory arbiter's request, return and
// memory-side signals.
//   fetch_req/fetch_addr   fetch issue request and PC
//   issue_accept           fetch issue accepted this cycle
//   aux_req/aux_addr       auxiliary read request and address
//   aux_grant              auxiliary request accepted this cycle
//   aux_rvalid/aux_rdata   auxiliary read return
//   mem_ren/mem_addr       memory read port command
//   mem_rdata              memory read data (fixed latency)
// Modports: slave = arbiter side, master = requesters plus memory side.
interface imem_arb_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        issue_accept;
  logic        aux_req;
  logic [31:0] aux_addr;
  logic        aux_grant;
  logic        aux_rvalid;
  logic [31:0] aux_rdata;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, aux_req, aux_addr, mem_rdata,
    output issue_accept, aux_grant, aux_rvalid, aux_rdata, mem_ren, mem_addr
  );

  modport master (
    output fetch_req, fetch_addr, aux_req, aux_addr, mem_rdata,
    input  issue_accept, aux_grant, aux_rvalid, aux_rdata, mem_ren, mem_addr
  );
endinterface

// File: rtl/imem_arb.sv
// imem_arb: owner selection for the single instruction-memory read port,
// shared between fetch (priority) and an auxiliary requester. Read returns
// are steered to the auxiliary requester through a MEM_LAT-deep ownership
// pipeline; fetch returns are aligned by the frontend pipe itself.
// Ports:
//   clk     clock, all state on the rising edge
//   rst     synchronous active-high reset
//   clk_en  global clock enable; low holds state and forces grants low
//   bus     imem_arb_if.slave (fetch, auxiliary and memory-port signals)
// Parameters: MEM_LAT (read latency, >= 1), STARVE_LIMIT (denied auxiliary
// cycles before a forced grant, >= 1).
// Build option: define IMEM_ARB_STARVE_EN to build the starvation counter;
// without it fetch has strict priority.
module imem_arb #(
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  imem_arb_if.slave  bus
);

  if (MEM_LAT < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("imem_arb: MEM_LAT and STARVE_LIMIT must be >= 1");
  end

  logic               run;
  logic               starve;
  logic               grant_aux;
  logic               issue_accept;
  logic               mem_ren;
  logic               aux_rvalid;
  logic [MEM_LAT-1:0] pipe_vld;
  logic [MEM_LAT-1:0] pipe_aux;

  assign run          = clk_en && !rst;
  assign grant_aux    = run && bus.aux_req && (!bus.fetch_req || starve);
  assign issue_accept = run && bus.fetch_req && !grant_aux;
  assign mem_ren      = issue_accept || grant_aux;

  assign bus.issue_accept = issue_accept;
  assign bus.aux_grant    = grant_aux;
  assign bus.mem_ren      = mem_ren;
  assign bus.mem_addr     = grant_aux ? bus.aux_addr : bus.fetch_addr;

  // Entry MEM_LAT-1 is the head: it describes the read whose data is on
  // mem_rdata this cycle. The memory is clock-enabled like this pipe, so
  // both advance only on clk_en cycles and stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_aux <= '0;
    end else if (clk_en) begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_aux[i] <= pipe_aux[i-1];
      end
      pipe_vld[0] <= mem_ren;
      pipe_aux[0] <= grant_aux;
    end
  end

  // rst gates the head as well, so a read landing in the reset cycle itself
  // is dropped rather than reported.
  assign aux_rvalid     = run && pipe_vld[MEM_LAT-1] && pipe_aux[MEM_LAT-1];
  assign bus.aux_rvalid = aux_rvalid;
  assign bus.aux_rdata  = aux_rvalid ? bus.mem_rdata : 32'h0;

`ifdef IMEM_ARB_STARVE_EN
  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Counts consecutive denied auxiliary cycles; saturates at the limit so the
  // forced grant persists until it is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (clk_en) begin
      if (!bus.aux_req || grant_aux) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  assign starve = (starve_cnt == CNT_MAX);
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arb.sv
module tb_imem_arb;
  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  int   checks   = 0;
  int   failures = 0;

  imem_arb_if bus ();

  imem_arb dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Memory model: 2-cycle read latency, clock-enabled like the arbiter.
  // Data is 0xDEADBEEF at 0x1000 and the inverted address elsewhere.
  logic [31:0] m0 = 32'h0;
  logic [31:0] m1 = 32'h0;
  always @(posedge clk) begin
    if (clk_en) begin
      m0 <= bus.mem_ren ? ((bus.mem_addr == 32'h1000) ? 32'hDEADBEEF : ~bus.mem_addr) : 32'h0;
      m1 <= m0;
    end
  end
  assign bus.mem_rdata = m1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // End the current cycle and move inputs just past the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic ar, input logic [31:0] aa);
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.aux_req    = ar;
    bus.aux_addr   = aa;
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 32'h1000);

    // Reset with both requesters active: everything quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_issue_accept", 32'(bus.issue_accept), 32'h0);
      chk("rst_aux_grant",    32'(bus.aux_grant),    32'h0);
      chk("rst_mem_ren",      32'(bus.mem_ren),      32'h0);
      chk("rst_aux_rvalid",   32'(bus.aux_rvalid),   32'h0);
      chk("rst_aux_rdata",    bus.aux_rdata,         32'h0);
      next_cycle();
    end

    // First cycle out of reset: fetch issues.
    rst = 1'b0;
    drive(1'b1, 32'h100, 1'b0, 32'h0);
    @(negedge clk);
    chk("post_rst_accept",   32'(bus.issue_accept), 32'h1);
    chk("post_rst_mem_addr", bus.mem_addr,          32'h100);
    chk("post_rst_mem_ren",  32'(bus.mem_ren),      32'h1);
    chk("post_rst_no_aux",   32'(bus.aux_grant),    32'h0);
    next_cycle();

    // Idle fetch: aux granted at once, data two cycles later.
    drive(1'b0, 32'h0, 1'b1, 32'h1000);
    @(negedge clk);
    chk("idle_aux_grant", 32'(bus.aux_grant),    32'h1);
    chk("idle_mem_addr",  bus.mem_addr,          32'h1000);
    chk("idle_no_accept", 32'(bus.issue_accept), 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("idle_c1_rvalid", 32'(bus.aux_rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("idle_c2_rvalid", 32'(bus.aux_rvalid), 32'h1);
    chk("idle_c2_rdata",  bus.aux_rdata,       32'hDEADBEEF);
    next_cycle();

    // Contention: fetch held high, aux requesting from cycle 0.
    drive(1'b1, 32'h200, 1'b1, 32'h2000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("cont_accept", 32'(bus.issue_accept), 32'h1);
      chk("cont_no_aux", 32'(bus.aux_grant),    32'h0);
      next_cycle();
    end
`ifdef IMEM_ARB_STARVE_EN
    @(negedge clk);
    chk("starve_aux_grant", 32'(bus.aux_grant),    32'h1);
    chk("starve_no_accept", 32'(bus.issue_accept), 32'h0);
    chk("starve_mem_addr",  bus.mem_addr,          32'h2000);
    next_cycle();
`else
    for (int i = 8; i < 50; i++) begin
      @(negedge clk);
      chk("strict_no_aux", 32'(bus.aux_grant), 32'h0);
      next_cycle();
    end
    drive(1'b0, 32'h200, 1'b1, 32'h2000);
    @(negedge clk);
    chk("strict_aux_grant", 32'(bus.aux_grant), 32'h1);
    chk("strict_mem_addr",  bus.mem_addr,       32'h2000);
    next_cycle();
`endif
    drive(1'b1, 32'h204, 1'b0, 32'h0);
    @(negedge clk);
    chk("cont_c1_rvalid", 32'(bus.aux_rvalid),   32'h0);
    chk("cont_c1_accept", 32'(bus.issue_accept), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("cont_c2_rvalid", 32'(bus.aux_rvalid), 32'h1);
    chk("cont_c2_rdata",  bus.aux_rdata,       32'hFFFFDFFF);
    next_cycle();

    // Interleaved: fetch on even cycles, aux on odd cycles 1,3,5.
    for (int i = 0; i < 8; i++) begin
      if (i >= 6)           drive(1'b0, 32'h0, 1'b0, 32'h0);
      else if (i % 2 == 0)  drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 32'h0);
      else                  drive(1'b0, 32'h0, 1'b1, 32'h3000 + 32'(i * 4));
      @(negedge clk);
      chk("ilv_grant", 32'(bus.aux_grant), (i < 6 && i % 2 == 1) ? 32'h1 : 32'h0);
      if (i >= 2 && (i - 2) % 2 == 1) begin
        chk("ilv_rvalid", 32'(bus.aux_rvalid), 32'h1);
        chk("ilv_rdata",  bus.aux_rdata,       ~(32'h3000 + 32'((i - 2) * 4)));
      end else begin
        chk("ilv_no_rvalid", 32'(bus.aux_rvalid), 32'h0);
      end
      next_cycle();
    end

    // Clock enable low for 3 cycles with one aux read in flight.
    drive(1'b0, 32'h0, 1'b1, 32'h4000);
    @(negedge clk);
    chk("ce_aux_grant", 32'(bus.aux_grant), 32'h1);
    next_cycle();
    clk_en = 1'b0;
    drive(1'b1, 32'h400, 1'b1, 32'h4004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ce_off_rvalid", 32'(bus.aux_rvalid),   32'h0);
      chk("ce_off_grant",  32'(bus.aux_grant),    32'h0);
      chk("ce_off_accept", 32'(bus.issue_accept), 32'h0);
      chk("ce_off_ren",    32'(bus.mem_ren),      32'h0);
      next_cycle();
    end
    clk_en = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("ce_e1_rvalid", 32'(bus.aux_rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("ce_e2_rvalid", 32'(bus.aux_rvalid), 32'h1);
    chk("ce_e2_rdata",  bus.aux_rdata,       32'hFFFFBFFF);
    next_cycle();

    // Reset while an aux read is in flight: the read is dropped.
    drive(1'b0, 32'h0, 1'b1, 32'h5000);
    @(negedge clk);
    chk("mid_aux_grant", 32'(bus.aux_grant), 32'h1);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(bus.aux_rvalid), 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_dropped_rvalid", 32'(bus.aux_rvalid), 32'h0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
